// File: rtl/differentiator_pkg.sv
// differentiator_pkg: shared constants and elaboration helpers for the comb chain
//   max_delay   : deepest differential delay a comb stage supports
//   clamp_delay : folds an out-of-range delay onto the legal 1..max_delay range
//   slice_lsb   : lowest kept bit when truncating an n-bit result to m bits
package differentiator_pkg;

    localparam int max_delay = 4;

    function automatic int clamp_delay(input int d);
        return (d < 1) ? 1 : ((d > max_delay) ? max_delay : d);
    endfunction

    function automatic int slice_lsb(input int n, input int m);
        return (m >= n) ? 0 : n - m;
    endfunction

endpackage

// File: rtl/differentiator_comb_stage.sv
// comb_stage: one comb section, o = i - i(d strobes ago), wrapping modulo 2^n
//   clk   : clock, all updates on posedge
//   clr   : asynchronous active-low clear of history and output register
//   flush : synchronous clear; a coincident strobe is dropped
//   i_stb : input valid, history only advances on accepted samples
//   i     : signed input sample
//   o_stb : registered valid, one cycle per accepted sample
//   o     : registered difference, held between strobes
module comb_stage
    import differentiator_pkg::*;
#(
    parameter int n = 17,
    parameter int d = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                flush,
    input  logic                i_stb,
    input  logic signed [n-1:0] i,
    output logic                o_stb,
    output logic signed [n-1:0] o
);

    localparam int dd = clamp_delay(d);

    // h[0] is the most recent accepted sample, h[dd-1] the one d strobes back
    logic [n-1:0] h [dd];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int k = 0; k < dd; k++) h[k] <= '0;
            o     <= '0;
            o_stb <= 1'b0;
        end else if (flush) begin
            for (int k = 0; k < dd; k++) h[k] <= '0;
            o     <= '0;
            o_stb <= 1'b0;
        end else begin
            o_stb <= i_stb;
            if (i_stb) begin
                o    <= i - h[dd-1];
                h[0] <= i;
                for (int k = 1; k < dd; k++) h[k] <= h[k-1];
            end
        end
    end

endmodule

// File: rtl/differentiator.sv
// differentiator: s cascaded comb stages forming the comb half of a CIC decimator
//   clk     : clock, all updates on posedge
//   clr     : asynchronous active-low reset of every stage
//   flush   : synchronous clear of all history and samples in flight
//   in_stb  : input sample strobe
//   in      : signed n-bit input sample
//   out_stb : one-cycle pulse per accepted sample, s edges after acceptance
//   out     : top m bits of the last stage's registered result (floor scaling)
module differentiator
    import differentiator_pkg::*;
#(
    parameter int n = 17,
    parameter int m = 16,
    parameter int s = 3,
    parameter int d = 1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                flush,
    input  logic                in_stb,
    input  logic signed [n-1:0] in,
    output logic                out_stb,
    output logic signed [m-1:0] out
);

    localparam int lsb = slice_lsb(n, m);

    logic [s:0]          stb;
    logic signed [n-1:0] dat [s+1];

    assign stb[0] = in_stb;
    assign dat[0] = in;

    for (genvar g = 0; g < s; g++) begin : g_stage
        comb_stage #(.n(n), .d(d)) u_stage (
            .clk   (clk),
            .clr   (clr),
            .flush (flush),
            .i_stb (stb[g]),
            .i     (dat[g]),
            .o_stb (stb[g+1]),
            .o     (dat[g+1])
        );
    end

    // The last stage's register is the output register; slicing it keeps latency at s edges
    assign out_stb = stb[s];
    assign out     = dat[s][lsb +: m];

endmodule
